// File: rtl/acc_core.sv
// acc_core: accumulator datapath with NAND/add/shift ALU, registered-read memory and op/valid/ready handshake
module acc_core #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] arg,
    output logic [WIDTH-1:0] bus,
    output logic             is_zero,
    output logic             carry,
    output logic             done
);
    typedef enum logic {IDLE, MEM} state_t;

    state_t            state, state_next;
    logic              ready_q;
    logic [2:0]        op_q;
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  rd_data;
    logic [WIDTH-1:0]  mem [0:(2**ADDR_W)-1];
    logic [ADDR_W-1:0] addr;
    logic [2:0]        cur_op;
    logic [WIDTH-1:0]  nxt_acc;
    logic              nxt_carry;
    logic [WIDTH:0]    sum;
    logic              accept, is_mem_op, exec, wr_en, upd_zero;

    assign op_ready  = ready_q && state == IDLE;
    assign accept    = op_valid && op_ready;
    assign is_mem_op = op == 3'd2 || op == 3'd4 || op == 3'd7;
    assign exec      = (accept && !is_mem_op) || state == MEM;
    assign cur_op    = state == MEM ? op_q : op;
    assign addr      = arg[ADDR_W-1:0];
    assign wr_en     = accept && op == 3'd3;
    assign upd_zero  = cur_op != 3'd0 && cur_op != 3'd3;
    assign sum       = {1'b0, acc} + {1'b0, rd_data};
    assign bus       = acc;

    // Next state: memory-operand ops take one extra cycle in MEM
    always_comb begin
        state_next = state == MEM ? IDLE : (accept && is_mem_op ? MEM : IDLE);
    end

    // ALU: operand comes from arg (immediate) or the registered memory read
    always_comb begin
        nxt_acc   = acc;
        nxt_carry = carry;
        case (cur_op)
            3'd1: nxt_acc = arg;
            3'd2: nxt_acc = rd_data;
            3'd4: nxt_acc = ~(acc & rd_data);
            3'd5: {nxt_carry, nxt_acc} = {acc, 1'b0};
            3'd6: {nxt_acc, nxt_carry} = {1'b0, acc};
            3'd7: {nxt_carry, nxt_acc} = sum;
            default: ;
        endcase
    end

    // Control and architectural state; ready rises one cycle after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            op_q    <= '0;
            acc     <= '0;
            is_zero <= 1'b1;
            carry   <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= 1'b1;
            done    <= exec;
            if (accept)
                op_q <= op;
            if (exec) begin
                acc   <= nxt_acc;
                carry <= nxt_carry;
                if (upd_zero)
                    is_zero <= nxt_acc == '0;
            end
        end
    end

    // Single-port memory: synchronous write, read data registered on acceptance
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[addr] <= acc;
        if (accept)
            rd_data <= mem[addr];
    end
endmodule
